// File: rtl/dct_pkg.sv
// Shared constants and types for the 8-point DCT/IDCT datapath
// (1-D transform stages and the row/column transpose buffer).
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_IDX_W  = 3;
    localparam int DCT_DATA_W = 16;

    localparam logic [DCT_IDX_W-1:0] DCT_LAST_IDX = DCT_IDX_W'(DCT_N - 1);

    typedef logic signed [DCT_DATA_W-1:0] dct_row_t [DCT_N];

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 element register bank: row-wide write port, column-wide
// combinational read port.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int N      = DCT_N
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [DCT_IDX_W-1:0]     wr_row,
    input  logic signed [DATA_W-1:0] wr_data [N],
    input  logic [DCT_IDX_W-1:0]     rd_col,
    output logic signed [DATA_W-1:0] rd_data [N]
);

    logic signed [DATA_W-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c];
            end
        end
    end

    // Reading down a column is what performs the transpose.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            rd_data[r] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the DCT row and column passes:
// rows are written into one bank while the other bank is read out by column.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int N      = DCT_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data [N],
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data [N],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last
);

    logic [1:0]           full;
    logic [1:0]           full_nxt;
    logic                 wr_sel;
    logic                 rd_sel;
    logic [DCT_IDX_W-1:0] wr_cnt;
    logic [DCT_IDX_W-1:0] rd_cnt;

    logic wr_fire;
    logic rd_fire;
    logic wr_done;
    logic rd_done;

    logic signed [DATA_W-1:0] rd_data0 [N];
    logic signed [DATA_W-1:0] rd_data1 [N];

    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_fire && (wr_cnt == DCT_LAST_IDX);
    assign rd_done = rd_fire && (rd_cnt == DCT_LAST_IDX);

    dct_tp_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_fire && !wr_sel),
        .wr_row  (wr_cnt),
        .wr_data (in_data),
        .rd_col  (rd_cnt),
        .rd_data (rd_data0)
    );

    dct_tp_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_fire && wr_sel),
        .wr_row  (wr_cnt),
        .wr_data (in_data),
        .rd_col  (rd_cnt),
        .rd_data (rd_data1)
    );

    // Fill and drain completions always hit different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_sel] = 1'b1;
        if (rd_done) full_nxt[rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) wr_sel <= !wr_sel;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_done) rd_sel <= !rd_sel;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_data[i] = rd_sel ? rd_data1[i] : rd_data0[i];
        end
    end

    assign out_first = (rd_cnt == '0);
    assign out_last  = (rd_cnt == DCT_LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed and randomised-handshake bench for dct_transpose_buf with a
// transpose scoreboard and stall-stability checks.
module tb_dct_transpose_buf;

    logic              clk;
    logic              rst_n;
    logic signed [15:0] in_data [8];
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] out_data [8];
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;

    int n_chk;
    int n_fail;

    // scoreboard: accepted rows of the current block, expected column elements
    logic signed [15:0] acc [8][8];
    int                 acc_n;
    logic signed [15:0] exp_q [$];
    int                 col_idx;

    logic               hold_vld;
    logic signed [15:0] hold_data [8];
    logic               hold_first;
    logic               hold_last;

    dct_transpose_buf #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_row(input int base);
        for (int c = 0; c < 8; c++) in_data[c] = 16'(base + c);
    endtask

    function automatic logic signed [15:0] rnd_elem();
        case ($urandom_range(0, 5))
            0:       return 16'sh8000;
            1:       return 16'sh7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Samples handshakes just before the edge, then advances one cycle.
    task automatic tick();
        #1;
        if (!rst_n) begin
            acc_n    = 0;
            col_idx  = 0;
            hold_vld = 1'b0;
            exp_q.delete();
        end else begin
            if (hold_vld) begin
                chk("stall_vld", 32'(out_valid), 32'd1);
                for (int i = 0; i < 8; i++) chk("stall_data", out_data[i], hold_data[i]);
                chk("stall_first", 32'(out_first), 32'(hold_first));
                chk("stall_last", 32'(out_last), 32'(hold_last));
            end
            hold_vld = out_valid && !out_ready;
            if (hold_vld) begin
                for (int i = 0; i < 8; i++) hold_data[i] = out_data[i];
                hold_first = out_first;
                hold_last  = out_last;
            end
            if (in_valid && in_ready) begin
                for (int c = 0; c < 8; c++) acc[acc_n][c] = in_data[c];
                acc_n++;
                if (acc_n == 8) begin
                    for (int c = 0; c < 8; c++)
                        for (int r = 0; r < 8; r++) exp_q.push_back(acc[r][c]);
                    acc_n = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() < 8) begin
                    chk("unexpected_col", 32'd1, 32'd0);
                end else begin
                    for (int i = 0; i < 8; i++) chk("col_data", out_data[i], exp_q.pop_front());
                    chk("col_first", 32'(out_first), 32'(col_idx == 0));
                    chk("col_last", 32'(out_last), 32'(col_idx == 7));
                    col_idx = (col_idx + 1) % 8;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_ovld", 32'(out_valid), 32'd0);
        chk("rst_irdy", 32'(in_ready), 32'd1);
    endtask

    task automatic send_rows(input int base, input int nrows, input logic orr);
        for (int r = 0; r < nrows; r++) begin
            set_row(base + r * 8);
            in_valid  = 1'b1;
            out_ready = orr;
            chk("send_irdy", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int bad;
        int rows_sent;
        int cyc;
        logic acc_now;

        n_chk = 0; n_fail = 0;
        acc_n = 0; col_idx = 0; hold_vld = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_row(0);

        // reset state
        tick();
        do_reset();

        // single block, hand-computed transpose
        send_rows(0, 8, 1'b1);
        chk("lat_ovld", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) chk("blk_col", out_data[i], 32'(i * 8 + c));
            chk("blk_first", 32'(out_first), 32'(c == 0));
            chk("blk_last", 32'(out_last), 32'(c == 7));
            tick();
        end
        chk("blk_empty", 32'(out_valid), 32'd0);

        // streaming: four back-to-back blocks
        do_reset();
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 32);
            set_row((i / 8) * 64 + (i % 8) * 8);
            if (i < 32 && !in_ready) bad++;
            if (out_valid !== (i >= 8)) bad++;
            tick();
        end
        chk("stream_handshake_errs", 32'(bad), 32'd0);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;

        // back-pressure: both banks fill, 17th row stalls
        do_reset();
        send_rows(0, 8, 1'b0);
        send_rows(64, 8, 1'b0);
        chk("bp_irdy_low", 32'(in_ready), 32'd0);
        set_row(128);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("bp_irdy_hold", 32'(in_ready), 32'd0);
        chk("bp_ovld", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (in_ready) bad++;
            tick();
        end
        chk("bp_irdy_during_drain", 32'(bad), 32'd0);
        chk("bp_irdy_rise", 32'(in_ready), 32'd1);
        tick();
        for (int r = 1; r < 8; r++) begin
            set_row(128 + r * 8);
            tick();
        end
        drain();

        // random handshakes with extreme signed values
        do_reset();
        rows_sent = 0;
        cyc = 0;
        for (int c = 0; c < 8; c++) in_data[c] = rnd_elem();
        while ((rows_sent < 160 || exp_q.size() > 0) && cyc < 4000) begin
            in_valid  = (rows_sent < 160) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            acc_now   = in_valid && in_ready;
            tick();
            if (acc_now) begin
                rows_sent++;
                for (int c = 0; c < 8; c++) in_data[c] = rnd_elem();
            end
            cyc++;
        end
        chk("rand_rows", 32'(rows_sent), 32'd160);
        chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;

        // reset mid-fill
        do_reset();
        send_rows(1000, 5, 1'b1);
        do_reset();
        send_rows(2000, 8, 1'b1);
        drain();

        // reset mid-drain
        do_reset();
        send_rows(3000, 8, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        do_reset();
        send_rows(4000, 8, 1'b1);
        drain();

        // simultaneous fill-complete and drain-complete
        do_reset();
        send_rows(256, 8, 1'b0);
        send_rows(512, 7, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        set_row(512 + 56);
        in_valid = 1'b1;
        chk("sim_irdy", 32'(in_ready), 32'd1);
        chk("sim_last", 32'(out_last), 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("sim_ovld", 32'(out_valid), 32'd1);
        chk("sim_first", 32'(out_first), 32'd1);
        chk("sim_d0", out_data[0], 32'd512);
        chk("sim_d7", out_data[7], 32'd568);
        chk("sim_irdy_after", 32'(in_ready), 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Ping-pong 8x8 transpose buffer between the row pass and the column pass of the 2-D 8-point DCT/IDCT datapath.
- Accepts one 8-element row per handshake and, once a full block is stored, emits the same block one column per handshake.
- Double buffering lets one bank fill while the other drains, sustaining 1 row in and 1 column out per cycle.

Parameters:
- DATA_W, 16, signed element width (matches the 1-D transform input width).
- N, 8, block dimension; fixed at 8, taken from the package constant.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  [DATA_W-1:0] x [N]  one row; element i is column i.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  buffer can accept a row this cycle.
- out_data  output  [DATA_W-1:0] x [N]  one column; element i is row i.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes the column this cycle.
- out_first  output  1  qualifies column 0 of a block; valid only with out_valid.
- out_last  output  1  qualifies column 7 of a block; valid only with out_valid.

Behaviour:
- Storage: bank[2][N][N] of DATA_W. Control registers:
  - full[1:0]
  - wr_sel (1 bit) and wr_cnt (3 bits)
  - rd_sel (1 bit) and rd_cnt (3 bits)
- Reset (rst_n low at an edge):
  - full=0, wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0.
  - Consequently in_ready=1 and out_valid=0 from the following cycle.
  - Bank data is not reset.
- Write side:
  - in_ready = !full[wr_sel], purely combinational from registers.
  - Write fires when in_valid && in_ready: bank[wr_sel][wr_cnt][*] <= in_data, and wr_cnt increments.
  - When the write fires with wr_cnt==7: full[wr_sel] <= 1, wr_sel toggles, wr_cnt wraps to 0.
- Read side:
  - out_valid = full[rd_sel].
  - out_data[i] = bank[rd_sel][i][rd_cnt].
  - out_first = (rd_cnt==0); out_last = (rd_cnt==7).
  - Read fires when out_valid && out_ready: rd_cnt increments.
  - When the read fires with rd_cnt==7: full[rd_sel] <= 0, rd_sel toggles, rd_cnt wraps to 0.
- Latency: row 7 accepted at edge k gives out_valid=1 with column 0 in the cycle after edge k, i.e. 1 cycle.
- Throughput: with in_valid and out_ready held high, sustained 1 row/cycle in and 1 column/cycle out. in_ready never drops.
- Back-pressure:
  - If out_ready stays low, both banks fill after 16 rows and in_ready drops.
  - in_ready rises in the cycle after the read of column 7 of the older block.
- Simultaneous events:
  - Write-complete and read-complete in the same cycle always target different banks. A bank is written only when not full and read only when full.
  - Both updates apply independently.
- Stability:
  - While out_valid && !out_ready, out_data/out_first/out_last hold stable.
  - No input may alter the bank being read.
- in_valid low: no state change on the write side, and partial-row counts are preserved indefinitely.
- Reset mid-operation:
  - Any partial or full block is discarded.
  - No column of a pre-reset block may appear after reset.
- out_data when out_valid=0 is don't-care and is not checked.
- Elements are passed through bit-exact; no arithmetic, no saturation.

Decomposition:
- dct_pkg holds:
  - DCT_N = 8
  - DCT_IDX_W = 3
  - typedef dct_row_t (array [DCT_N] of signed [DATA_W-1:0], default 16) for row/column vectors
- The 1-D transform block and this buffer both use dct_pkg.
- One sub-module is natural: dct_tp_bank, a single 8x8 register bank.
  - Write port: row index, row data, write enable.
  - Read port: column index, column data (combinational).
  - dct_transpose_buf instantiates two dct_tp_bank and holds the ping-pong control.

Test Plan:
- Single block: rows r=0..7 with element c = r*8+c, out_ready=1 -> out_valid 1 cycle after row 7. Column c = {c, 8+c, ..., 56+c}. out_first on column 0, out_last on column 7.
- Streaming: 4 back-to-back blocks, block b offset by b*64, in_valid=out_ready=1 -> in_ready constantly 1. 32 columns in order, 1/cycle after the initial 8+1 latency.
- Back-pressure: out_ready=0, 17 rows offered -> in_ready drops after row 16 and row 17 stalls. Assert out_ready for 8 cycles -> block 0 columns emitted, in_ready rises the next cycle, row 17 accepted.
- Random stalls: random in_valid/out_ready (50%) over 20 blocks with signed values incl. -32768 and 32767 -> scoreboard matches transpose bit-exact, and out_data is stable during stalls.
- Reset mid-fill and mid-drain: rst_n low 1 cycle after 5 rows, then after column 3 of a drain -> out_valid=0 and in_ready=1 next cycle. A fresh block afterwards outputs only new data.
- Simultaneous complete: block 1 row 7 accepted in the same cycle as block 0 column 7 read -> full toggles correctly, and block 1 column 0 appears the next cycle.
